// File: rtl/pixfetch_pkg.sv
// Shared constants and types for the palette-index fetch path.
// Optional underrun tracking is enabled with PIXFETCH_UNDERRUN_EN.
package pixfetch_pkg;

  localparam logic [9:0] H_START   = 10'd64;
  localparam logic [9:0] H_ACTIVE  = 10'd512;
  localparam logic [9:0] V_ACTIVE  = 10'd480;
  localparam logic [9:0] V_PRELOAD = 10'd524;
  localparam int         MAP_ROW_WORDS = 64;

  typedef enum logic {
    IDLE,
    FETCH
  } fetch_state_t;

  typedef logic [3:0] color_idx_t;

endpackage

// File: rtl/line_buffer_pp.sv
// Ping-pong pair of 256x4 true-line buffers.
// Writes four indices per cycle at base..base+3 with 8-bit wrap.
module line_buffer_pp
  import pixfetch_pkg::*;
(
  input  logic       clk,
  input  logic       wr_en,
  input  logic       wr_bank,
  input  logic [7:0] wr_base,
  input  logic [15:0] wr_data,
  input  logic       rd_bank,
  input  logic [7:0] rd_addr,
  output color_idx_t rd_data
);

  color_idx_t mem0 [256];
  color_idx_t mem1 [256];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int p = 0; p < 4; p++) begin
        if (wr_bank)
          mem1[wr_base + 8'(p)] <= wr_data[4*p +: 4];
        else
          mem0[wr_base + 8'(p)] <= wr_data[4*p +: 4];
      end
    end
  end

  assign rd_data = rd_bank ? mem1[rd_addr] : mem0[rd_addr];

endmodule

// File: rtl/pixel_index_fetcher.sv
// Fetches map rows one true line ahead into ping-pong buffers and emits Color_idx.
// PIXFETCH_UNDERRUN_EN adds a sticky underrun output.
module pixel_index_fetcher
  import pixfetch_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        pix_en,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [7:0]  scroll_x,
  input  logic [7:0]  scroll_y,
  input  logic [1:0]  Map_idx,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_data,
  output color_idx_t  Color_idx,
  output logic [7:0]  Addr_X,
  output logic [7:0]  Addr_Y,
  output logic        in_window
`ifdef PIXFETCH_UNDERRUN_EN
  ,
  output logic        underrun
`endif
);

  fetch_state_t state;
  logic [7:0]   sx;
  logic [7:0]   sy;
  logic [1:0]   map;
  logic         fbank;

  logic         preload;
  logic         trig;
  logic [7:0]   t_next;
  logic [7:0]   row_next;
  logic [1:0]   map_next;
  logic [5:0]   col;
  logic         ack_ok;
  logic         last;
  logic         win;
  logic [7:0]   ax;
  color_idx_t   rd_data;

  always_comb begin
    preload  = pix_en && DrawX == 10'd0 && DrawY == V_PRELOAD;
    trig     = preload ||
               (pix_en && DrawX == 10'd0 && !DrawY[0] &&
                DrawY < V_ACTIVE - 10'd2);
    t_next   = preload ? 8'd0 : DrawY[8:1] + 8'd1;
    row_next = t_next + (preload ? scroll_y : sy);
    map_next = preload ? Map_idx : map;
    col      = mem_addr[5:0];
    ack_ok   = state == FETCH && mem_ack;
    last     = col == 6'(MAP_ROW_WORDS - 1);
    win      = DrawX >= H_START && DrawX < H_START + H_ACTIVE &&
               DrawY < V_ACTIVE;
    ax       = 8'((DrawX - H_START) >> 1);
  end

  // A new trigger always wins: an in-flight line is abandoned at c=0.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      sx       <= '0;
      sy       <= '0;
      map      <= '0;
      fbank    <= 1'b0;
    end else begin
      if (preload) begin
        sx  <= scroll_x;
        sy  <= scroll_y;
        map <= Map_idx;
      end
      if (trig) begin
        state    <= FETCH;
        mem_req  <= 1'b1;
        mem_addr <= {map_next, row_next, 6'd0};
        fbank    <= t_next[0];
      end else if (ack_ok) begin
        if (last) begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end else begin
          mem_addr[5:0] <= col + 6'd1;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Color_idx <= '0;
      Addr_X    <= '0;
      Addr_Y    <= '0;
      in_window <= 1'b0;
    end else if (pix_en) begin
      in_window <= win;
      if (win) begin
        Addr_X    <= ax;
        Addr_Y    <= DrawY[8:1];
        Color_idx <= rd_data;
      end else begin
        Color_idx <= '0;
      end
    end
  end

  line_buffer_pp u_buf (
    .clk     (Clk),
    .wr_en   (ack_ok),
    .wr_bank (fbank),
    .wr_base ({col, 2'b00} - sx),
    .wr_data (mem_data),
    .rd_bank (DrawY[1]),
    .rd_addr (ax),
    .rd_data (rd_data)
  );

`ifdef PIXFETCH_UNDERRUN_EN
  logic [1:0] ready;
  logic       miss;

  assign miss = pix_en && DrawX == H_START && DrawY < V_ACTIVE &&
                !DrawY[0] && !ready[DrawY[1]];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ready    <= '0;
      underrun <= 1'b0;
    end else begin
      if (ack_ok && last)
        ready[fbank] <= 1'b1;
      if (trig)
        ready[t_next[0]] <= 1'b0;
      if (preload)
        underrun <= 1'b0;
      else if ((trig && state == FETCH) || miss)
        underrun <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/pixel_index_fetcher.md
Name: pixel_index_fetcher

Overview:
- Producer side of the palette-index path: generates the 4-bit Color_idx (plus Addr_X/Addr_Y) that the color mapper turns into VGA RGB.
- Fetches true-screen rows (256x240, 4-bit indices, 2x scaled to 512x480 at DrawX 64..575) from map memory into ping-pong line buffers. Fetching always runs one true line ahead of display.
- Supports per-frame scroll and map selection.

Parameters:
- H_START, 64, first DrawX of the active 512-pixel window.
- V_PRELOAD, 524, DrawY at which line 0 is fetched and scroll/map are latched.
- MAP_ROW_WORDS, 64, 16-bit words per map row (4 px/word, pixel 0 in bits [3:0]).

Ports:
- Clk  in  1  system clock (50 MHz)
- Reset  in  1  synchronous, active-high
- pix_en  in  1  one-Clk pulse per VGA pixel; DrawX/DrawY valid when high
- DrawX  in  10  current VGA column
- DrawY  in  10  current VGA row
- scroll_x  in  8  horizontal scroll, true pixels
- scroll_y  in  8  vertical scroll, true rows
- Map_idx  in  2  map select
- mem_req  out  1  read request
- mem_addr  out  16  {map, row[7:0], col[5:0]}
- mem_ack  in  1  read complete; mem_data valid this cycle
- mem_data  in  16  four 4-bit indices
- Color_idx  out  4  palette index for the color mapper
- Addr_X  out  8  true-screen x
- Addr_Y  out  8  true-screen y
- in_window  out  1  pixel lies inside the 512x480 window

Behaviour:
- Reset: Color_idx=0, Addr_X=0, Addr_Y=0, in_window=0, mem_req=0, mem_addr=0, FSM=IDLE, latched scroll/map=0. Buffer contents are don't-care.
- Latch: at pix_en && DrawX==0 && DrawY==V_PRELOAD, latch scroll_x, scroll_y, Map_idx for the whole frame.
- Fetch trigger (pix_en && DrawX==0):
  - DrawY==V_PRELOAD: fetch line t=0 into buf0.
  - DrawY==2t with t in 0..238: fetch line t+1 into buf[(t+1)&1].
- Fetched map row = (t + scroll_y) mod 256, using 8-bit wrap.
- FSM:
  - IDLE: goes to FETCH on trigger; column counter c=0.
  - FETCH: mem_req=1, mem_addr={map,row,c}, both held stable until mem_ack. On ack, pixel p of mem_data goes to buffer entry (4c+p-scroll_x) mod 256, all four written in the ack cycle. Then c increments and the request for c+1 is presented the next cycle (mem_req may stay high). After c=63 is acked, go to IDLE, drop mem_req, mark the line ready.
- Trigger while in FETCH: any ack in that same cycle is written first. The fetch then restarts at c=0 for the new line. Underrun is recorded.
- Display (registered, 1-Clk latency): on an edge with pix_en high, in_window = (DrawX in [H_START, H_START+511]) && DrawY<480.
  - Inside the window: Addr_X=(DrawX-H_START)>>1, Addr_Y=DrawY>>1, Color_idx=buf[Addr_Y[0]][Addr_X].
  - Outside the window: Color_idx=0, Addr_X/Addr_Y hold their last values.
  - Outputs hold when pix_en is low.
- A line displayed before its fetch completes shows stale buffer data. This is not an error beyond the underrun record.
- Reset mid-fetch: mem_req drops on that edge and the outstanding transaction is abandoned.

Optional Feature:
- Macro PIXFETCH_UNDERRUN_EN.
- Defined:
  - Adds output port underrun (1 bit), cleared by Reset and at the V_PRELOAD trigger.
  - Set sticky when a trigger arrives while in FETCH, or when display of line t begins (DrawX==H_START, DrawY==2t) before line t is ready.
- Undefined: no port, no tracking logic; fetch behaviour is identical.

Decomposition:
- Package pixfetch_pkg holds:
  - H_START, H_ACTIVE=512, V_ACTIVE=480, V_PRELOAD, MAP_ROW_WORDS
  - typedef fetch_state_t {IDLE, FETCH}
  - typedef color_idx_t (logic [3:0])
- Sub-module line_buffer_pp: two 256x4 arrays, 4-entry write port (base address plus wrap), one read port, bank select per port.

Test Plan:
- Reset mid-FETCH (c=10): next edge mem_req=0, Color_idx=0, in_window=0; no further requests until the next trigger.
- Zero-wait memory (mem_ack tied 1), map 1, scroll 0, word (row r, col c) = {4{c[3:0]}}: DrawY=0, DrawX=64 -> Color_idx=0; DrawX=72 -> 1; mem_addr of line 5 = {2'd1,8'd5,c}.
- scroll_x=3, mem_data=16'h3210 at col 0, other columns 0: Addr_X=253,254,255,0 -> Color_idx 0,1,2,3.
- scroll_y=250 latched at DrawY=524; changed to 0 mid-frame -> line 10 still fetched from row 4 (260 mod 256); new value takes effect next frame.
- mem_ack held low until after DrawX==0 of DrawY=2 -> fetch restarts at c=0 for line 2; with PIXFETCH_UNDERRUN_EN, underrun=1 until the next DrawY=524 trigger.
- DrawX=63 and DrawX=576 -> in_window=0, Color_idx=0; pix_en low for 5 cycles -> outputs unchanged.
